ex_mem_reg: RTL and testbench

Pipeline register between the execute stage (64-bit ALU and its bitwise AND/OR/XOR units, adder, shifter) and the memory stage of the 5-stage ARM-subset CPU. It captures the ALU result, destination register, memory-control bits and store data on each clock. It owns the architectural NZCV flag register and provides a same-cycle flag bypass for conditional branches. It supports stall, flush and a valid bit so bubbles propagate cleanly.

---
 rtl/ex_mem_reg.sv | 114 +++++++++++
 tb/tb_ex_mem_reg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures the execute-stage result and control bits,
// owns the architectural NZCV flags and bypasses freshly computed flags to EX branches.
module ex_mem_reg #(
    parameter int DW = 64,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_carry,
    input  logic          alu_overflow,
    input  logic          set_flags,
    input  logic [RW-1:0] rd,
    input  logic          reg_write,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [DW-1:0] store_data,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write,
    output logic          out_mem_read,
    output logic          out_mem_write,
    output logic [DW-1:0] out_store_data,
    output logic [3:0]    flags,
    output logic [3:0]    cond_flags
);

    localparam logic [RW-1:0] XZR = RW'(31);

    logic          valid_q,     valid_d;
    logic [DW-1:0] result_q,    result_d;
    logic [RW-1:0] rd_q,        rd_d;
    logic          reg_write_q, reg_write_d;
    logic          mem_read_q,  mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [DW-1:0] store_q,     store_d;
    logic [3:0]    flags_q,     flags_d;

    logic       load;
    logic       flag_load;
    logic [3:0] new_flags;

    assign load      = in_valid & ~stall & ~flush;
    assign flag_load = load & set_flags;
    assign new_flags = {alu_result[DW-1], ~|alu_result, alu_carry, alu_overflow};

    always_comb begin
        valid_d     = valid_q;
        result_d    = result_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        store_d     = store_q;
        flags_d     = flags_q;

        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (!stall) begin
            // Data fields load even on a bubble; consumers qualify them with out_valid.
            valid_d     = in_valid;
            result_d    = alu_result;
            rd_d        = rd;
            store_d     = store_data;
            reg_write_d = in_valid & reg_write & (rd != XZR);
            mem_read_d  = in_valid & mem_read;
            mem_write_d = in_valid & mem_write;
        end

        if (flag_load) begin
            flags_d = new_flags;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            store_q     <= '0;
            flags_q     <= 4'b0000;
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            store_q     <= store_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_result     = result_q;
    assign out_rd         = rd_q;
    assign out_reg_write  = reg_write_q;
    assign out_mem_read   = mem_read_q;
    assign out_mem_write  = mem_write_q;
    assign out_store_data = store_q;
    assign flags          = flags_q;
    assign cond_flags     = flag_load ? new_flags : flags_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed scenarios plus randomized traffic for ex_mem_reg, checked against a
// behavioural model of the stage held in plain variables.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [63:0] alu_result;
    logic        alu_carry;
    logic        alu_overflow;
    logic        set_flags;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] store_data;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [63:0] out_store_data;
    logic [3:0]  flags;
    logic [3:0]  cond_flags;

    int checks = 0;
    int failures = 0;

    // Reference state of the MEM-side instruction and the flag register
    logic        m_valid, m_rw, m_mr, m_mw;
    logic [63:0] m_result, m_sd;
    logic [4:0]  m_rd;
    logic [3:0]  m_flags;

    ex_mem_reg #(.DW(64), .RW(5)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .set_flags(set_flags), .rd(rd), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .store_data(store_data),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_store_data(out_store_data),
        .flags(flags), .cond_flags(cond_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags_of(input logic [63:0] r, input logic c, input logic v);
        return {r[63], (r == 64'd0), c, v};
    endfunction

    function automatic logic [3:0] exp_cond();
        if (in_valid && set_flags && !stall && !flush)
            return flags_of(alu_result, alu_carry, alu_overflow);
        return m_flags;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        m_result = 0; m_sd = 0; m_rd = 0; m_flags = 4'b0000;
    endtask

    task automatic model_edge();
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end else if (!stall) begin
            if (in_valid) begin
                m_valid  = 1;
                m_result = alu_result;
                m_rd     = rd;
                m_sd     = store_data;
                m_rw     = reg_write && (rd != 5'd31);
                m_mr     = mem_read;
                m_mw     = mem_write;
                if (set_flags) m_flags = flags_of(alu_result, alu_carry, alu_overflow);
            end else begin
                m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, out_valid, m_valid);
        chk({tag, ".reg_write"}, out_reg_write, m_rw);
        chk({tag, ".mem_read"}, out_mem_read, m_mr);
        chk({tag, ".mem_write"}, out_mem_write, m_mw);
        chk({tag, ".flags"}, flags, m_flags);
        if (m_valid) begin
            chk({tag, ".result"}, out_result, m_result);
            chk({tag, ".rd"}, out_rd, m_rd);
            chk({tag, ".store_data"}, out_store_data, m_sd);
        end
    endtask

    // Called at a negedge with inputs already set: check bypass, clock once, check registers.
    task automatic tick(input string tag);
        #1;
        chk({tag, ".cond_flags"}, cond_flags, exp_cond());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic set_idle();
        in_valid = 0; alu_result = 0; alu_carry = 0; alu_overflow = 0; set_flags = 0;
        rd = 0; reg_write = 0; mem_read = 0; mem_write = 0; store_data = 0;
        stall = 0; flush = 0;
    endtask

    initial begin
        reset_n = 0;
        set_idle();
        model_reset();
        #12;
        @(negedge clk);
        check_outputs("reset_init");
        chk("reset_init.result", out_result, 64'd0);
        reset_n = 1;

        // Asynchronous reset with a live instruction in MEM
        in_valid = 1; alu_result = 64'h1234; rd = 5'd7; reg_write = 1; mem_read = 1;
        store_data = 64'h55; set_flags = 1; alu_carry = 1;
        tick("preload");
        chk("preload.valid_const", out_valid, 1'b1);
        #2 reset_n = 0;
        #1;
        model_reset();
        chk("async_rst.valid", out_valid, 1'b0);
        chk("async_rst.result", out_result, 64'd0);
        chk("async_rst.rd", out_rd, 5'd0);
        chk("async_rst.store", out_store_data, 64'd0);
        chk("async_rst.rw", out_reg_write, 1'b0);
        chk("async_rst.mr", out_mem_read, 1'b0);
        chk("async_rst.flags", flags, 4'b0000);
        @(negedge clk);
        reset_n = 1;
        set_idle();
        tick("bubble_after_rst");

        // Logical op setting N
        set_idle();
        in_valid = 1; alu_result = 64'h8000_0000_0000_0005; set_flags = 1; rd = 5'd3; reg_write = 1;
        #1 chk("logic.cond_const", cond_flags, 4'b1000);
        tick("logic");
        chk("logic.flags_const", flags, 4'b1000);
        chk("logic.rd_const", out_rd, 5'd3);
        chk("logic.rw_const", out_reg_write, 1'b1);

        // Zero result to XZR with carry
        set_idle();
        in_valid = 1; alu_result = 64'd0; alu_carry = 1; set_flags = 1; rd = 5'd31; reg_write = 1;
        tick("zero_xzr");
        chk("zero_xzr.flags_const", flags, 4'b0110);
        chk("zero_xzr.rw_const", out_reg_write, 1'b0);
        chk("zero_xzr.valid_const", out_valid, 1'b1);

        // Three stalled edges with changing inputs
        set_idle();
        stall = 1; in_valid = 1; alu_result = 64'hFFFF; set_flags = 1; rd = 5'd9; reg_write = 1;
        for (int i = 0; i < 3; i++) begin
            alu_carry = i[0];
            #1 chk("stall.cond_eq_flags", cond_flags, 4'b0110);
            tick("stall");
            chk("stall.flags_const", flags, 4'b0110);
            chk("stall.result_const", out_result, 64'd0);
        end

        // Flush while stalled
        set_idle();
        stall = 1; flush = 1; in_valid = 1; set_flags = 1; mem_write = 1; alu_result = 64'h77;
        tick("flush_stall");
        chk("flush_stall.valid_const", out_valid, 1'b0);
        chk("flush_stall.mw_const", out_mem_write, 1'b0);
        chk("flush_stall.flags_const", flags, 4'b0110);

        // Store pass-through
        set_idle();
        in_valid = 1; mem_write = 1; store_data = 64'hDEAD_BEEF_0123_4567; rd = 5'd4;
        tick("store");
        chk("store.mw_const", out_mem_write, 1'b1);
        chk("store.sd_const", out_store_data, 64'hDEAD_BEEF_0123_4567);
        chk("store.flags_const", flags, 4'b0110);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int sel;
            in_valid     = ($urandom_range(0, 3) != 0);
            stall        = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            set_flags    = $urandom_range(0, 1);
            alu_carry    = $urandom_range(0, 1);
            alu_overflow = $urandom_range(0, 1);
            reg_write    = $urandom_range(0, 1);
            rd           = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            sel = $urandom_range(0, 3);
            case (sel)
                0: alu_result = 64'd0;
                1: alu_result = {1'b1, 31'($urandom), $urandom};
                default: alu_result = {$urandom, $urandom};
            endcase
            store_data = {$urandom, $urandom};
            sel = $urandom_range(0, 2);
            mem_read  = (sel == 1);
            mem_write = (sel == 2);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
